sw_led_pio_slave: RTL
=====================

SW_LED_PIO_SLAVE -- requirements
Module: sw_led_pio_slave

Interface
REQ-001 Parameter: WIDTH, default 10, number of switch inputs and LED outputs.
REQ-002 Parameter: DEBOUNCE_CYCLES, default 50000, number of stable clk_clk cycles required before a switch change is accepted (1 ms at 50 MHz).
REQ-003 Port: clk_clk  input  1  single clock; all logic on the rising edge.
REQ-004 Port: reset_reset  input  1  synchronous, active-high reset.
REQ-005 Port: avs_address  input  2  word address of the register.
REQ-006 Port: avs_read  input  1  read strobe.
REQ-007 Port: avs_write  input  1  write strobe.
REQ-008 Port: avs_writedata  input  32  write data.
REQ-009 Port: avs_readdata  output  32  read data.
REQ-010 Port: avs_readdatavalid  output  1  read data qualifier.
REQ-011 Port: irq  output  1  level interrupt to the HPS.
REQ-012 Port: sw_in  input  WIDTH  raw, asynchronous board switches.
REQ-013 Port: led_out  output  WIDTH  board LED drive.

Function
REQ-014 The block SHALL be the Avalon-MM responder for the HPS lightweight bridge: no waitrequest, writes take one cycle, and read latency is fixed at 1.
REQ-015 The register map SHALL be: 0 DATA (RO, debounced switches), 1 LED (RW), 2 EDGE (read, write-1-to-clear), 3 IRQMASK (RW). Bits [31:WIDTH] SHALL read 0 and SHALL ignore writes.
REQ-016 A write to DATA SHALL have no effect.
REQ-017 sw_in SHALL pass through a 2-flop synchronizer before any other use.
REQ-018 Debounce SHALL use one shared counter. When synchronized value == stable, the counter SHALL clear. Otherwise the counter SHALL increment. When it reaches DEBOUNCE_CYCLES-1 while still differing, stable SHALL load the synchronized value and the counter SHALL clear.
REQ-019 A glitch shorter than DEBOUNCE_CYCLES SHALL NOT change stable. Any return to equality SHALL restart the count from 0.
REQ-020 Total latency from a sw_in change to DATA reflecting it SHALL be exactly 2 + DEBOUNCE_CYCLES cycles for a clean step.
REQ-021 EDGE[i] SHALL set in the cycle after stable[i] changes, on either rising or falling edge, and SHALL stay set until cleared.
REQ-022 A write to EDGE with writedata[i]=1 SHALL clear EDGE[i]. If a new edge on bit i occurs in the same cycle, set SHALL win.
REQ-023 irq SHALL be registered, equal to |(EDGE & IRQMASK), and valid one cycle after EDGE or IRQMASK changes.
REQ-024 led_out SHALL equal the LED register directly, with no additional delay after the write cycle.
REQ-025 avs_readdatavalid SHALL pulse high exactly one cycle after each cycle with avs_read=1. Back-to-back reads SHALL give back-to-back valid pulses.
REQ-026 avs_readdata SHALL hold its last value when avs_readdatavalid=0.
REQ-027 If read and write target the same register in one cycle, the read SHALL return the pre-write value.
REQ-028 avs_read and avs_write asserted together to different registers SHALL both complete.

Reset
REQ-029 While reset_reset=1, the following SHALL clear to 0 at the next clock edge: LED, EDGE, IRQMASK, stable, synchronizer flops, debounce counter, avs_readdata, avs_readdatavalid and irq.
REQ-030 After reset, stable=0. Switches already high at reset SHALL therefore be accepted after 2+DEBOUNCE_CYCLES cycles and SHALL set EDGE.
REQ-031 Reset asserted mid-debounce SHALL abandon the count. Reset asserted in the cycle after a read SHALL suppress avs_readdatavalid.

Verification (DEBOUNCE_CYCLES=8 for bench)
REQ-032 Write LED=0x2A5, then read address 1 -> led_out=0x2A5 the next cycle; readdatavalid one cycle after read with readdata=0x000002A5.
REQ-033 Step sw_in 0x000->0x001 and hold -> DATA reads 0x001 exactly 10 cycles after the step; EDGE=0x001.
REQ-034 Pulse sw_in[3] high for 5 cycles -> DATA, EDGE and irq unchanged.
REQ-035 Set IRQMASK=0x001, let edge on bit 0 occur -> irq=1 one cycle after EDGE sets. Write EDGE=0x001 -> irq=0 two cycles later. Write EDGE=0x001 in the same cycle a new bit-0 edge arrives -> EDGE[0] remains 1.
REQ-036 Read address 2 in the same cycle as writing EDGE=0x3FF with EDGE=0x005 -> readdata=0x005, then EDGE=0. Assert reset during a debounce count -> all outputs 0, count restarts.

Source files
------------

// File: rtl/sw_led_pio_slave.sv
// ---------------------------------------------------------------------------
// sw_led_pio_slave
//
// Avalon-MM responder for the HPS lightweight bridge that exposes the board
// switches (synchronized + debounced) and drives the board LEDs. No
// waitrequest; writes complete in one cycle and reads have a fixed latency
// of one cycle.
//
// Register map (word addresses):
//   0 DATA    RO   debounced switch state
//   1 LED     RW   LED drive, mirrored directly on led_out
//   2 EDGE    R/W1C sticky change flags, one per switch (either direction)
//   3 IRQMASK RW   per-bit enable of EDGE into irq
// Bits [31:WIDTH] read as zero and ignore writes.
//
// Ports:
//   clk_clk            single clock, rising edge
//   reset_reset        synchronous, active-high reset
//   avs_address        register word address
//   avs_read/avs_write read / write strobes
//   avs_writedata      write data
//   avs_readdata       read data, held between reads
//   avs_readdatavalid  one-cycle pulse, one cycle after each read strobe
//   irq                registered level interrupt, |(EDGE & IRQMASK)
//   sw_in              raw asynchronous switches
//   led_out            LED drive
// ---------------------------------------------------------------------------
module sw_led_pio_slave #(
    parameter int WIDTH           = 10,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk_clk,
    input  logic             reset_reset,
    input  logic [1:0]       avs_address,
    input  logic             avs_read,
    input  logic             avs_write,
    input  logic [31:0]      avs_writedata,
    output logic [31:0]      avs_readdata,
    output logic             avs_readdatavalid,
    output logic             irq,
    input  logic [WIDTH-1:0] sw_in,
    output logic [WIDTH-1:0] led_out
);

    localparam int               CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_LED  = 2'd1;
    localparam logic [1:0] ADDR_EDGE = 2'd2;
    localparam logic [1:0] ADDR_MASK = 2'd3;

    logic [WIDTH-1:0] sync1_q,      sync1_d;
    logic [WIDTH-1:0] sync2_q,      sync2_d;
    logic [WIDTH-1:0] stable_q,     stable_d;
    logic [WIDTH-1:0] stable_dly_q, stable_dly_d;
    logic [CNT_W-1:0] cnt_q,        cnt_d;
    logic [WIDTH-1:0] led_q,        led_d;
    logic [WIDTH-1:0] edge_q,       edge_d;
    logic [WIDTH-1:0] mask_q,       mask_d;
    logic             irq_q,        irq_d;
    logic [31:0]      rdata_q,      rdata_d;
    logic             rvalid_q,     rvalid_d;

    logic [WIDTH-1:0] wdata_lo;
    logic [WIDTH-1:0] edge_set;
    logic [WIDTH-1:0] edge_clr;

    assign wdata_lo = avs_writedata[WIDTH-1:0];

    // Upper write-data bits are intentionally ignored.
    if (WIDTH < 32) begin : g_unused
        logic unused_wdata_hi;
        assign unused_wdata_hi = ^avs_writedata[31:WIDTH];
    end

    always_comb begin
        // Two-flop synchronizer; nothing else looks at sw_in.
        sync1_d = sw_in;
        sync2_d = sync1_q;

        // One counter shared by all bits: any bit differing keeps it
        // running, full agreement clears it. A bounce back to equality
        // therefore restarts the whole window.
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_d = sync2_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        // Edge flags set the cycle after stable moves, hence the delayed copy.
        stable_dly_d = stable_q;
        edge_set     = stable_q ^ stable_dly_q;

        led_d    = led_q;
        mask_d   = mask_q;
        edge_clr = '0;
        if (avs_write) begin
            case (avs_address)
                ADDR_LED:  led_d    = wdata_lo;
                ADDR_EDGE: edge_clr = wdata_lo;
                ADDR_MASK: mask_d   = wdata_lo;
                default:   ;
            endcase
        end

        // Set beats clear when both hit the same bit in one cycle.
        edge_d = (edge_q & ~edge_clr) | edge_set;

        irq_d = |(edge_q & mask_q);

        // Read mux uses current register values, so a same-cycle write to
        // the same register returns the pre-write contents.
        rvalid_d = avs_read;
        rdata_d  = rdata_q;
        if (avs_read) begin
            case (avs_address)
                ADDR_DATA: rdata_d = 32'(stable_q);
                ADDR_LED:  rdata_d = 32'(led_q);
                ADDR_EDGE: rdata_d = 32'(edge_q);
                ADDR_MASK: rdata_d = 32'(mask_q);
                default:   rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            stable_q     <= '0;
            stable_dly_q <= '0;
            cnt_q        <= '0;
            led_q        <= '0;
            edge_q       <= '0;
            mask_q       <= '0;
            irq_q        <= 1'b0;
            rdata_q      <= '0;
            rvalid_q     <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            stable_q     <= stable_d;
            stable_dly_q <= stable_dly_d;
            cnt_q        <= cnt_d;
            led_q        <= led_d;
            edge_q       <= edge_d;
            mask_q       <= mask_d;
            irq_q        <= irq_d;
            rdata_q      <= rdata_d;
            rvalid_q     <= rvalid_d;
        end
    end

    assign avs_readdata = rdata_q;
    // A read accepted just before reset must not report valid data while
    // reset is already asserted.
    assign avs_readdatavalid = rvalid_q & ~reset_reset;
    assign irq     = irq_q;
    assign led_out = led_q;

endmodule
